// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports, two write ports (E, M), same-cycle
// write-to-read bypass, per-register pending scoreboard and a multi-cycle sweep-clear engine.
module regfile_mp #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          init,
  output logic          ready,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic          bsya,
  output logic          bsyb,
  input  logic          claim_en,
  input  logic [AW-1:0] claim_wn,
  input  logic          we0,
  input  logic [AW-1:0] wn0,
  input  logic [DW-1:0] d0,
  input  logic          we1,
  input  logic [AW-1:0] wn1,
  input  logic [DW-1:0] d1
);

  localparam int unsigned DEPTH   = 2 ** AW;
  localparam logic [AW:0] CntLast = (AW + 1)'(DEPTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StSweep
  } state_e;

  state_e            state_q, state_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [DW-1:0]     regs_q [DEPTH];
  logic [DW-1:0]     regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  logic idle;
  logic wr0, wr1, claim_ok;

  assign idle  = (state_q == StIdle);
  assign ready = idle;

  // Effective write/claim strobes: gated off during a sweep and for the hardwired zero register.
  assign wr0      = idle & we0 & ~(ZERO_REG && (wn0 == '0));
  assign wr1      = idle & we1 & ~(ZERO_REG && (wn1 == '0));
  assign claim_ok = idle & claim_en & ~(ZERO_REG && (claim_wn == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (init) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      StSweep: begin
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (state_q == StSweep) begin
      regs_d[cnt_q[AW-1:0]] = '0;
      pend_d[cnt_q[AW-1:0]] = 1'b0;
    end else begin
      // Port 1 is applied last so it wins an address conflict; claim wins over a clearing write.
      if (wr0) begin
        regs_d[wn0] = d0;
        pend_d[wn0] = 1'b0;
      end
      if (wr1) begin
        regs_d[wn1] = d1;
        pend_d[wn1] = 1'b0;
      end
      if (claim_ok) begin
        pend_d[claim_wn] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      regs_q  <= regs_d;
    end
  end

  function automatic logic [DW-1:0] rd_data(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = regs_q[a];
    if (BYPASS) begin
      if (wr1 && (wn1 == a)) begin
        v = d1;
      end else if (wr0 && (wn0 == a)) begin
        v = d0;
      end
    end
    if (!idle || (ZERO_REG && (a == '0))) begin
      v = '0;
    end
    return v;
  endfunction

  function automatic logic rd_busy(input logic [AW-1:0] a);
    logic b;
    b = pend_q[a];
    if (BYPASS && ((wr0 && (wn0 == a)) || (wr1 && (wn1 == a)))) begin
      b = 1'b0;
    end
    if (!idle) begin
      b = 1'b0;
    end
    return b;
  endfunction

  always_comb begin
    qa   = rd_data(rna);
    qb   = rd_data(rnb);
    bsya = rd_busy(rna);
    bsyb = rd_busy(rnb);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic, all checked
// against an array-based reference model of the register file, scoreboard and sweep.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          clr, init, ready;
  logic [AW-1:0] rna, rnb, claim_wn, wn0, wn1;
  logic [DW-1:0] qa, qb, d0, d1;
  logic          bsya, bsyb, claim_en, we0, we1;

  always #5 clk = ~clk;

  regfile_mp #(
    .DW      (DW),
    .AW      (AW),
    .ZERO_REG(1'b1),
    .BYPASS  (1'b1)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .init    (init),
    .ready   (ready),
    .rna     (rna),
    .rnb     (rnb),
    .qa      (qa),
    .qb      (qb),
    .bsya    (bsya),
    .bsyb    (bsyb),
    .claim_en(claim_en),
    .claim_wn(claim_wn),
    .we0     (we0),
    .wn0     (wn0),
    .d0      (d0),
    .we1     (we1),
    .wn1     (wn1),
    .d1      (d1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register contents, pending bits, remaining sweep edges and sweep index.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_pend [DEPTH];
  int            m_left = 0;
  int            m_idx  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_q(input logic [AW-1:0] a);
    if (m_left > 0 || a == 0) return '0;
    if (we1 && wn1 == a) return d1;
    if (we0 && wn0 == a) return d0;
    return m_mem[a];
  endfunction

  function automatic logic exp_bsy(input logic [AW-1:0] a);
    if (m_left > 0) return 1'b0;
    if ((we0 && wn0 == a) || (we1 && wn1 == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_edge();
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
      m_left = 0;
    end else if (m_left > 0) begin
      m_mem[m_idx]  = '0;
      m_pend[m_idx] = 1'b0;
      m_idx++;
      m_left--;
    end else begin
      if (init) begin
        m_left = DEPTH;
        m_idx  = 0;
      end
      if (we0 && wn0 != 0) begin
        m_mem[wn0]  = d0;
        m_pend[wn0] = 1'b0;
      end
      if (we1 && wn1 != 0) begin
        m_mem[wn1]  = d1;
        m_pend[wn1] = 1'b0;
      end
      if (claim_en && claim_wn != 0) m_pend[claim_wn] = 1'b1;
    end
  endtask

  task automatic idle_in();
    clr      = 1'b0;
    init     = 1'b0;
    claim_en = 1'b0;
    we0      = 1'b0;
    we1      = 1'b0;
  endtask

  // Check all outputs against the model, then take one clock edge and advance the model.
  task automatic step();
    #2;
    check_eq("ready", ready, (m_left == 0));
    check_eq("qa", qa, exp_q(rna));
    check_eq("qb", qb, exp_q(rnb));
    check_eq("bsya", bsya, exp_bsy(rna));
    check_eq("bsyb", bsyb, exp_bsy(rnb));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_traffic();
    we0      = 1'($urandom_range(0, 1));
    we1      = 1'($urandom_range(0, 1));
    claim_en = 1'($urandom_range(0, 2) == 0);
    wn0      = AW'($urandom_range(0, 7));
    wn1      = AW'($urandom_range(0, 7));
    claim_wn = AW'($urandom_range(0, 7));
    rna      = AW'($urandom_range(0, 7));
    rnb      = AW'($urandom_range(0, DEPTH - 1));
    d0       = $urandom;
    d1       = $urandom;
  endtask

  int cnt;

  initial begin
    idle_in();
    rna = '0; rnb = '0; claim_wn = '0; wn0 = '0; wn1 = '0; d0 = '0; d1 = '0;
    clr = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    idle_in();

    // Reset clears data and pending state
    we0 = 1'b1; wn0 = 5; d0 = 32'hDEAD_BEEF; claim_en = 1'b1; claim_wn = 6;
    step();
    idle_in();
    rna = 5; rnb = 6;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    #2;
    check_eq("rst_r5", qa, 32'h0);
    check_eq("rst_bsy", bsyb, 1'b0);
    check_eq("rst_ready", ready, 1'b1);
    step();

    // Dual write conflict and r0
    we0 = 1'b1; we1 = 1'b1; wn0 = 3; wn1 = 3; d0 = 32'h11; d1 = 32'h22;
    step();
    idle_in();
    rna = 3;
    #2 check_eq("dual_r3", qa, 32'h22);
    step();
    we0 = 1'b1; wn0 = 0; d0 = 32'hFFFF_FFFF; we1 = 1'b1; wn1 = 0; d1 = 32'h1;
    rna = 0;
    #2 check_eq("r0_byp", qa, 32'h0);
    step();
    idle_in();
    #2 check_eq("r0_read", qa, 32'h0);
    step();

    // Bypass
    rna = 7; we0 = 1'b1; wn0 = 7; d0 = 32'hABCD;
    #2 check_eq("byp0", qa, 32'hABCD);
    we1 = 1'b1; wn1 = 7; d1 = 32'h1234;
    #1 check_eq("byp1", qa, 32'h1234);
    step();
    idle_in();
    step();

    // Scoreboard
    claim_en = 1'b1; claim_wn = 9; rna = 9;
    step();
    idle_in();
    #2 check_eq("claim_bsy", bsya, 1'b1);
    step();
    we0 = 1'b1; wn0 = 9; d0 = 32'h99;
    #2 check_eq("wr_clr_byp", bsya, 1'b0);
    step();
    idle_in();
    #2 check_eq("wr_clr_after", bsya, 1'b0);
    step();
    claim_en = 1'b1; claim_wn = 9; we1 = 1'b1; wn1 = 9; d1 = 32'h5;
    step();
    idle_in();
    #2 check_eq("claim_wins", bsya, 1'b1);
    step();

    // Sweep: fill every register, leave pending bits set, then clear
    for (int i = 1; i < DEPTH; i++) begin
      we0 = 1'b1; wn0 = AW'(i); d0 = 32'h100 + i;
      claim_en = 1'b1; claim_wn = AW'((i % (DEPTH - 1)) + 1);
      rna = AW'(i - 1);
      step();
    end
    idle_in();
    init = 1'b1;
    step();
    idle_in();
    cnt = 0;
    while (ready == 1'b0 && cnt < 100) begin
      rand_traffic();
      init = 1'($urandom_range(0, 1));
      step();
      cnt++;
    end
    idle_in();
    check_eq("sweep_len", cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      rna = AW'(i); rnb = AW'(DEPTH - 1 - i);
      #2;
      check_eq("sweep_q", qa, 32'h0);
      check_eq("sweep_bsy", bsya | bsyb, 1'b0);
      step();
    end

    // Reset mid-sweep
    for (int i = 1; i < DEPTH; i += 3) begin
      we0 = 1'b1; wn0 = AW'(i); d0 = $urandom | 32'h1;
      step();
    end
    idle_in();
    init = 1'b1;
    step();
    idle_in();
    for (int i = 0; i < 10; i++) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    #2 check_eq("midsweep_ready", ready, 1'b1);
    we0 = 1'b1; wn0 = 4; d0 = 32'h55; rna = 31; rnb = 13;
    #1;
    check_eq("midsweep_r31", qa, 32'h0);
    check_eq("midsweep_r13", qb, 32'h0);
    step();
    idle_in();
    rna = 4;
    #2 check_eq("post_clr_wr", qa, 32'h55);
    step();

    // Randomized traffic including occasional init and clr
    for (int n = 0; n < 1500; n++) begin
      rand_traffic();
      init = 1'($urandom_range(0, 59) == 0);
      clr  = 1'($urandom_range(0, 99) == 0);
      step();
    end
    idle_in();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
